// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: default datapath sizing and the operand type.
package coproc_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned SYNC_STAGES = 2;

    typedef logic [DATA_W-1:0] operand_t;

endpackage

// File: rtl/port_capture_if.sv
// Operand stream from the capture stage to the compute core (valid/ready).
interface port_capture_if #(
    parameter int unsigned DATA_W = coproc_pkg::DATA_W
) ();

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered head; push allowed while full if popping.
module sync_fifo import coproc_pkg::*; #(
    parameter int unsigned DATA_W = coproc_pkg::DATA_W,
    parameter int unsigned DEPTH  = coproc_pkg::FIFO_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_next;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr + 1'b1;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
            // Head comes from the incoming word only when it becomes the sole entry.
            if (do_push && ((count == '0) || (do_pop && (count == CNT_W'(1))))) begin
                head <= push_data;
            end else if (do_pop) begin
                head <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/port_capture.sv
// MCU parallel-port capture: synchronizes data/tag/run, accepts one operand per tag toggle.
module port_capture import coproc_pkg::*; #(
    parameter int unsigned DATA_W      = coproc_pkg::DATA_W,
    parameter int unsigned FIFO_DEPTH  = coproc_pkg::FIFO_DEPTH,
    parameter int unsigned SYNC_STAGES = coproc_pkg::SYNC_STAGES,
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] port_e,
    input  logic              tag_in,
    input  logic              run,
    port_capture_if.master    stream,
    output logic              ack_tag,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0]    data_pipe [SYNC_STAGES];
    logic [SYNC_STAGES:0] tag_pipe;
    logic [SYNC_STAGES-1:0] run_pipe;
    logic [DATA_W-1:0]    data_sync;
    logic                 tag_sync;
    logic                 run_sync;
    logic                 tag_last;
    logic                 pending;
    logic                 accept;
    logic                 pop;
    logic                 fifo_valid;
    logic [DATA_W-1:0]    fifo_head;

    assign data_sync = data_pipe[SYNC_STAGES-1];
    assign tag_sync  = tag_pipe[SYNC_STAGES];
    assign run_sync  = run_pipe[SYNC_STAGES-1];

    // Tag runs one stage longer than data so the data is settled before the toggle is seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                data_pipe[i] <= '0;
            end
            tag_pipe <= '0;
            run_pipe <= '0;
            tag_last <= 1'b0;
        end else begin
            data_pipe[0] <= port_e;
            run_pipe[0]  <= run;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                data_pipe[i] <= data_pipe[i-1];
                run_pipe[i]  <= run_pipe[i-1];
            end
            tag_pipe <= {tag_pipe[SYNC_STAGES-1:0], tag_in};
            if (accept) begin
                tag_last <= tag_sync;
            end
        end
    end

    assign pending = (tag_sync != tag_last);
    assign pop     = fifo_valid && stream.out_ready;
    assign accept  = pending && run_sync && (!full || pop);

    // The acknowledge is by definition the last accepted tag.
    assign ack_tag = tag_last;

    assign stream.out_data  = fifo_head;
    assign stream.out_valid = fifo_valid;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (accept),
        .push_data (data_sync),
        .pop       (pop),
        .head      (fifo_head),
        .valid     (fifo_valid),
        .full      (full),
        .count     (count)
    );

endmodule

// File: tb/tb_port_capture.sv
// Directed self-checking bench for port_capture with hand-computed expectations.
module tb_port_capture;
    import coproc_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] port_e;
    logic       tag_in;
    logic       run;
    logic       ack_tag;
    logic       full;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    port_capture_if #(.DATA_W(8)) bus ();

    port_capture #(
        .DATA_W      (8),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .port_e  (port_e),
        .tag_in  (tag_in),
        .run     (run),
        .stream  (bus),
        .ack_tag (ack_tag),
        .full    (full),
        .count   (count)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        port_e = d;
        tag_in = ~tag_in;
    endtask

    task automatic wait_ack(input int limit, output int cycles);
        cycles = 0;
        while (ack_tag !== tag_in && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; run = 1'b1; tag_in = 1'b0; port_e = 8'h00; bus.out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", bus.out_data); end
        checks++; if (ack_tag !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", ack_tag); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", full); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    endtask

    task automatic test_single;
        bus.out_ready = 1'b1;
        send(8'h05);
        repeat (3) tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_e3_valid got %b exp 0", bus.out_valid); end
        checks++; if (ack_tag !== 1'b0) begin errors++; $display("FAIL single_e3_ack got %b exp 0", ack_tag); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_e4_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h05) begin errors++; $display("FAIL single_e4_data got %h exp 05", bus.out_data); end
        checks++; if (ack_tag !== 1'b1) begin errors++; $display("FAIL single_e4_ack got %b exp 1", ack_tag); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_e4_count got %0d exp 1", count); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_e5_valid got %b exp 0", bus.out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_e5_count got %0d exp 0", count); end
    endtask

    task automatic test_backpressure;
        logic [7:0] words [4];
        logic [7:0] drain [4];
        int cyc;
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        drain = '{8'h22, 8'h33, 8'h44, 8'h55};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(words[i]);
            wait_ack(20, cyc);
            checks++; if (cyc !== 4) begin errors++; $display("FAIL bp_ack_latency word %0d got %0d exp 4", i, cyc); end
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL bp_full got %b exp 1", full); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_count got %0d exp 4", count); end
        checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL bp_head got %h exp 11", bus.out_data); end
        send(8'h55);
        repeat (10) tick();
        checks++; if (ack_tag !== ~tag_in) begin errors++; $display("FAIL bp_stall_ack got %b exp %b", ack_tag, ~tag_in); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_stall_count got %0d exp 4", count); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (ack_tag !== tag_in) begin errors++; $display("FAIL bp_late_ack got %b exp %b", ack_tag, tag_in); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.out_data !== drain[i]) begin errors++; $display("FAIL bp_drain_data %0d got %h exp %h", i, bus.out_data, drain[i]); end
            checks++; if (count !== 3'(4 - i)) begin errors++; $display("FAIL bp_drain_count %0d got %0d exp %0d", i, count, 4 - i); end
            tick();
        end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty_valid got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_run_gating;
        logic old_tag;
        run = 1'b0;
        repeat (3) tick();
        old_tag = tag_in;
        send(8'hA0);
        repeat (8) tick();
        checks++; if (ack_tag !== old_tag) begin errors++; $display("FAIL run_hold_ack got %b exp %b", ack_tag, old_tag); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL run_hold_count got %0d exp 0", count); end
        run = 1'b1;
        repeat (2) tick();
        checks++; if (ack_tag !== old_tag) begin errors++; $display("FAIL run_e2_ack got %b exp %b", ack_tag, old_tag); end
        tick();
        checks++; if (ack_tag !== tag_in) begin errors++; $display("FAIL run_e3_ack got %b exp %b", ack_tag, tag_in); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL run_e3_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_data !== 8'hA0) begin errors++; $display("FAIL run_e3_data got %h exp a0", bus.out_data); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL run_drain_count got %0d exp 0", count); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(8'h31 + 8'(i));
            wait_ack(20, cyc);
            checks++; if (cyc !== 4) begin errors++; $display("FAIL mid_fill_latency %0d got %0d exp 4", i, cyc); end
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_fill_count got %0d exp 3", count); end
        reset = 1'b1; tag_in = 1'b1; port_e = 8'h77;
        tick();
        reset = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", bus.out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", count); end
        checks++; if (ack_tag !== 1'b0) begin errors++; $display("FAIL mid_rst_ack got %b exp 0", ack_tag); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL mid_rst_full got %b exp 0", full); end
        repeat (3) tick();
        checks++; if (ack_tag !== 1'b0) begin errors++; $display("FAIL mid_e3_ack got %b exp 0", ack_tag); end
        tick();
        checks++; if (ack_tag !== 1'b1) begin errors++; $display("FAIL mid_e4_ack got %b exp 1", ack_tag); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL mid_e4_count got %0d exp 1", count); end
        checks++; if (bus.out_data !== 8'h77) begin errors++; $display("FAIL mid_e4_data got %h exp 77", bus.out_data); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_drain_count got %0d exp 0", count); end
    endtask

    task automatic test_wrap;
        logic [15:0] rdy_pat;
        logic [7:0]  expected;
        int          sent;
        int          got;
        int          cyc;
        rdy_pat  = 16'b1011_0010_1110_0101;
        expected = 8'h01;
        sent     = 0;
        got      = 0;
        cyc      = 0;
        while (got < 10 && cyc < 400) begin
            bus.out_ready = rdy_pat[cyc % 16];
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                checks++; if (bus.out_data !== expected) begin errors++; $display("FAIL wrap_data got %h exp %h", bus.out_data, expected); end
                expected++;
                got++;
            end
            if (ack_tag === tag_in && sent < 10) begin
                sent++;
                send(8'(sent));
            end
            tick();
            cyc++;
        end
        checks++; if (got !== 10) begin errors++; $display("FAIL wrap_received got %0d exp 10", got); end
        bus.out_ready = 1'b0;
        repeat (2) tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_final_count got %0d exp 0", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_run_gating();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
